octave_tone_gen: RTL and testbench
==================================

Name: octave_tone_gen

Overview:
- Downstream consumer of the octave select state `oct_switch`.
- Takes a base note half-period count and the 2-bit octave select and produces a glitch-free square-wave tone for the synthesizer mixer/PWM stage.
- Each octave step down doubles the half-period.
- Note and octave changes are applied only at full-period boundaries, so the output never emits a runt pulse.

Parameters:
- CNT_W, 16, width of the base half-period input `note_div`. Internal counters are CNT_W+3 bits.

Ports:
- clk  input  1  system clock
- nrst  input  1  reset, asynchronous, active-low
- note_on  input  1  level; 1 = a key is held
- note_div  input  CNT_W  half-period in clk cycles at octave 0; 0 = silence
- oct_switch  input  2  octave select; 00 = base, each +1 = one octave lower
- wave_out  output  1  square-wave tone
- active  output  1  1 while the generator is in RUN
- period_done  output  1  one-cycle pulse at each completed full period

Behaviour:
- Reset (async, nrst=0): state=IDLE, cnt=0, h_act=0, wave_out=0, active=0, period_done=0.
- Target half-period: h_tgt = {3'b0,note_div} << oct_switch, width CNT_W+3, so it never overflows. Octave 3 = 8x note_div.
- States: IDLE, RUN. All outputs are registered.
- IDLE behaviour:
  - wave_out=0, active=0, cnt held at 0.
  - If note_on=1 and note_div!=0 at edge N: after edge N, state=RUN, wave_out=1, active=1, cnt=0, h_act=h_tgt. Latency is 1 cycle.
- RUN behaviour, each edge:
  - If cnt != h_act-1: cnt <= cnt+1.
  - Otherwise, half-period end: cnt <= 0.
    - If wave_out=1: wave_out <= 0.
    - If wave_out=0: full-period boundary.
- Full-period boundary actions:
  - period_done=1 for that one cycle.
  - If note_on=0 or h_tgt=0: go to IDLE. wave_out stays 0, active <= 0.
  - Otherwise: wave_out <= 1, h_act <= h_tgt. The new note/octave takes effect from this period.
- Resulting waveform: high for h_act cycles, then low for h_act cycles. Full period = 2*h_act.
- Changes to note_div, oct_switch or note_on in mid-period have no effect until the next boundary.
- Note-off mid-period: the current period always completes. There is no truncation.
- note_on re-asserted before the boundary: the tone continues seamlessly.
- h_act=1 (note_div=1, oct 0): wave_out toggles every cycle.
- Reset mid-RUN: immediate return to reset values. No boundary wait.
- period_done is 0 in IDLE and on every non-boundary cycle.

Optional Feature:
- Macro: OCT_TONE_IMMEDIATE_EN.
- Without the macro: behaviour is exactly as above (boundary-latched updates).
- With the macro, in RUN: if h_tgt != h_act and h_tgt != 0, then at the next edge the generator restarts the period. cnt <= 0, wave_out <= 1, h_act <= h_tgt, and no period_done pulse.
- Restart priority: the restart has priority over a half-period end in the same cycle.
- Unchanged with the macro: h_tgt=0 and note-off remain boundary-latched.

Test Plan:
- Basic tone: reset, note_div=4, oct_switch=0, note_on=1 -> wave_out is 1 for 4 cycles and 0 for 4 cycles, repeating. period_done pulses every 8 cycles. active=1 from the cycle after note_on.
- Octave change mid-period: oct_switch 0->2 at cycle 2 of a high phase with note_div=4 -> the current period finishes 4/4. The next period is 16 high / 16 low. With OCT_TONE_IMMEDIATE_EN: the next cycle starts a 16/16 period with wave_out=1 and no period_done.
- Note-off mid-period: note_on drops during the high phase with note_div=3 -> the remaining high and 3 low cycles complete, period_done pulses, then IDLE with wave_out=0 and active=0. No further toggles.
- Silence / boundary values: note_div=0 with note_on=1 -> remains IDLE, wave_out=0.
- Max octave, no overflow: note_div=2^16-1, oct_switch=3 -> half-period = 524280 cycles, with no wrap.
- Minimum half-period: note_div=1, oct_switch=0 -> wave_out toggles every cycle.
- Reset mid-run: assert nrst=0 asynchronously during a low phase -> all outputs are 0 immediately. After release with note_on=1, the first high phase starts 1 cycle after the first edge.

Source files
------------

// File: rtl/octave_tone_gen.sv
// rtl/octave_tone_gen.sv - square-wave tone generator with octave select, boundary-latched updates
// Optional macro OCT_TONE_IMMEDIATE_EN: restart the period as soon as the target half-period changes.
module octave_tone_gen #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             note_on,
  input  logic [CNT_W-1:0] note_div,
  input  logic [1:0]       oct_switch,
  output logic             wave_out,
  output logic             active,
  output logic             period_done
);

  localparam int W = CNT_W + 3;
  localparam logic [W-1:0] ONE = W'(1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state, state_nxt;
  logic [W-1:0]   cnt, cnt_nxt;
  logic [W-1:0]   h_act, h_act_nxt;
  logic [W-1:0]   h_tgt;
  logic           wave_nxt, active_nxt, pd_nxt;
  logic           restart;

  // Three spare top bits absorb the octave-3 shift, so the target never wraps.
  assign h_tgt = {3'b000, note_div} << oct_switch;

`ifdef OCT_TONE_IMMEDIATE_EN
  assign restart = (state == RUN) && (h_tgt != h_act) && (h_tgt != '0);
`else
  assign restart = 1'b0;
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state       <= IDLE;
      cnt         <= '0;
      h_act       <= '0;
      wave_out    <= 1'b0;
      active      <= 1'b0;
      period_done <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      h_act       <= h_act_nxt;
      wave_out    <= wave_nxt;
      active      <= active_nxt;
      period_done <= pd_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    h_act_nxt  = h_act;
    wave_nxt   = wave_out;
    active_nxt = active;
    pd_nxt     = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt    = '0;
        wave_nxt   = 1'b0;
        active_nxt = 1'b0;
        if (note_on && (note_div != '0)) begin
          state_nxt  = RUN;
          wave_nxt   = 1'b1;
          active_nxt = 1'b1;
          h_act_nxt  = h_tgt;
        end
      end
      RUN: begin
        if (restart) begin
          cnt_nxt   = '0;
          wave_nxt  = 1'b1;
          h_act_nxt = h_tgt;
        end else if (cnt != h_act - ONE) begin
          cnt_nxt = cnt + ONE;
        end else begin
          cnt_nxt = '0;
          if (wave_out) begin
            wave_nxt = 1'b0;
          end else begin
            // Full-period boundary: the only point where note/octave/note-off are sampled.
            pd_nxt = 1'b1;
            if (!note_on || (h_tgt == '0)) begin
              state_nxt  = IDLE;
              active_nxt = 1'b0;
            end else begin
              wave_nxt  = 1'b1;
              h_act_nxt = h_tgt;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_octave_tone_gen.sv
// tb/tb_octave_tone_gen.sv - self-checking bench for octave_tone_gen
module tb_octave_tone_gen;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        note_on = 1'b0;
  logic [15:0] note_div = '0;
  logic [1:0]  oct_switch = '0;
  logic        wave_out, active, period_done;

  logic        m_on = 1'b0;
  logic [3:0]  m_div = '0;
  logic [1:0]  m_oct = '0;
  logic        m_wave, m_active, m_pd;

  int checks = 0;
  int fails  = 0;

  octave_tone_gen #(.CNT_W(16)) dut (
    .clk(clk), .nrst(nrst), .note_on(note_on), .note_div(note_div),
    .oct_switch(oct_switch), .wave_out(wave_out), .active(active),
    .period_done(period_done)
  );

  octave_tone_gen #(.CNT_W(4)) dut_max (
    .clk(clk), .nrst(nrst), .note_on(m_on), .note_div(m_div),
    .oct_switch(m_oct), .wave_out(m_wave), .active(m_active),
    .period_done(m_pd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] div;
    logic [1:0]  oct;
    int          half;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_half(input logic lvl, output int n);
    n = 0;
    while (wave_out == lvl && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    note_on = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
  endtask

  initial begin
    int hi, lo, n;
    vecs[0] = '{16'd4, 2'd0, 4};
    vecs[1] = '{16'd3, 2'd1, 6};
    vecs[2] = '{16'd1, 2'd0, 1};
    vecs[3] = '{16'd5, 2'd2, 20};
    vecs[4] = '{16'd2, 2'd3, 16};

    #1;
    chk("reset_wave", wave_out, 0);
    chk("reset_active", active, 0);
    chk("reset_pd", period_done, 0);
    @(negedge clk);

    foreach (vecs[i]) begin
      do_reset();
      note_div = vecs[i].div;
      oct_switch = vecs[i].oct;
      note_on = 1'b1;
      @(negedge clk);
      chk($sformatf("v%0d_start_wave", i), wave_out, 1);
      chk($sformatf("v%0d_start_active", i), active, 1);
      chk($sformatf("v%0d_start_pd", i), period_done, 0);
      run_half(1'b1, hi);
      run_half(1'b0, lo);
      chk($sformatf("v%0d_high", i), hi, vecs[i].half);
      chk($sformatf("v%0d_low", i), lo, vecs[i].half);
      chk($sformatf("v%0d_boundary_pd", i), period_done, 1);
      chk($sformatf("v%0d_boundary_wave", i), wave_out, 1);
    end

    // Silence: note_div=0 never leaves IDLE.
    do_reset();
    note_div = 16'd0;
    oct_switch = 2'd0;
    note_on = 1'b1;
    repeat (5) @(negedge clk);
    chk("silence_wave", wave_out, 0);
    chk("silence_active", active, 0);

    // Octave change during cycle 2 of a high phase.
    do_reset();
    note_div = 16'd4;
    oct_switch = 2'd0;
    note_on = 1'b1;
    @(negedge clk);
    hi = 0;
    while (wave_out && hi < 200) begin
      hi++;
      if (hi == 3) oct_switch = 2'd2;
      @(negedge clk);
    end
    run_half(1'b0, lo);
`ifdef OCT_TONE_IMMEDIATE_EN
    chk("oct_cur_high", hi, 19);
    chk("oct_cur_low", lo, 16);
`else
    chk("oct_cur_high", hi, 4);
    chk("oct_cur_low", lo, 4);
`endif
    chk("oct_boundary_pd", period_done, 1);
    run_half(1'b1, hi);
    run_half(1'b0, lo);
    chk("oct_next_high", hi, 16);
    chk("oct_next_low", lo, 16);

    // Note-off early in the high phase: period completes, then IDLE.
    do_reset();
    note_div = 16'd3;
    oct_switch = 2'd0;
    note_on = 1'b1;
    @(negedge clk);
    note_on = 1'b0;
    run_half(1'b1, hi);
    lo = 0;
    while (!period_done && lo < 200) begin
      lo++;
      @(negedge clk);
    end
    chk("off_high", hi, 3);
    chk("off_low", lo, 3);
    chk("off_wave", wave_out, 0);
    chk("off_active", active, 0);
    n = 0;
    repeat (10) begin
      @(negedge clk);
      n += int'(wave_out) + int'(period_done) + int'(active);
    end
    chk("off_quiet", n, 0);

    // Max octave on a narrow instance: 15 << 3 = 120 needs all CNT_W+3 bits.
    do_reset();
    m_div = 4'd15;
    m_oct = 2'd3;
    m_on = 1'b1;
    @(negedge clk);
    hi = 0;
    while (m_wave && hi < 300) begin
      hi++;
      @(negedge clk);
    end
    lo = 0;
    while (!m_wave && lo < 300) begin
      lo++;
      @(negedge clk);
    end
    chk("max_high", hi, 120);
    chk("max_low", lo, 120);
    chk("max_pd", m_pd, 1);
    m_on = 1'b0;

    // Asynchronous reset during a low phase.
    do_reset();
    note_div = 16'd4;
    oct_switch = 2'd0;
    note_on = 1'b1;
    @(negedge clk);
    repeat (5) @(negedge clk);
    chk("rst_pre_low", wave_out, 0);
    #2 nrst = 1'b0;
    #1;
    chk("rst_async_wave", wave_out, 0);
    chk("rst_async_active", active, 0);
    chk("rst_async_pd", period_done, 0);
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    chk("rst_restart_wave", wave_out, 1);
    chk("rst_restart_active", active, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
